uop_fill: RTL and testbench
===========================

# uop_fill

Write side of the micro-op buffer. Accepts single decoded instructions with their branch tags from the upstream stage, pairs them into two-instruction entries, and writes the entries into an internal circular buffer. The fetch stage reads the buffer through an asynchronous address/data port. Occupancy is tracked against the fetch stage's read address, and the block back-pressures upstream when the buffer is full.

## Interface

Parameters:
- `UOP_BUF_SIZE`, default 16: number of entries; power of two, at least 4.
- `MAX_PREDICT_DEPTH_BITS`, default 4: branch tag width B.
- `UOP_BUF_WIDTH`, default 72: entry width; must equal 64+2*B.
- `NOP_INSTR`, default 32'h0000_0013: pad instruction for an unpaired final slot.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `clear`, in, 1: pipeline flush. Synchronous; same effect as reset on pointers and pairing state.
- `in_valid`, in, 1: upstream presents an instruction this cycle.
- `in_instr`, in, 32: instruction word.
- `in_tag`, in, B: branch tag of `in_instr`.
- `in_last`, in, 1: close the current pair after this instruction. A lone instruction is padded.
- `stalled`, out, 1: combinational. High means the upstream must hold its inputs; nothing is accepted.
- `rd_addr`, in, log2(UOP_BUF_SIZE): fetch stage read address (its current pointer).
- `uop`, out, UOP_BUF_WIDTH: combinational read of the entry at `rd_addr`.
- `uop_avail`, out, 1: registered. High when entry `rd_addr` holds unread data (`wr_ptr != rd_addr`).

## Operation

Entry format:
- [31:0] = slot-1 instruction.
- [63:32] = slot-2 instruction.
- [64+2B-1:64+B] = slot-1 tag.
- [64+B-1:64] = slot-2 tag.

State:
- `wr_ptr` (log2 SIZE bits, wraps modulo SIZE).
- Pairing FSM: EMPTY or HALF.
- Half registers `h_instr` and `h_tag`.
- Memory array of SIZE × WIDTH. The memory is not reset.

Definitions:
- full = (`wr_ptr`+1 mod SIZE) == `rd_addr`. One slot is always kept unused, so capacity is SIZE−1 entries.
- `stalled` = full.
- accept = `in_valid` && !`stalled`.

FSM transitions on accept:
- EMPTY, `in_last`=0: latch `in_instr`/`in_tag` into the half registers; go to HALF. No write.
- EMPTY, `in_last`=1: write {tag `in_tag`, tag 0, `NOP_INSTR`, `in_instr`}. Slot 1 is the input, slot 2 is NOP with tag 0. Increment `wr_ptr`; stay EMPTY.
- HALF, any `in_last`: write entry with slot 1 = half registers and slot 2 = input. Increment `wr_ptr`; go to EMPTY.

Other rules:
- No accept: state, pointer and memory are unchanged.
- Back-pressure: `stalled` is high whenever full, including in EMPTY state where no write would occur. This is a deliberate simplification.
- `clear` or `reset`: `wr_ptr`←0, FSM←EMPTY, `uop_avail`←0. Any held half-instruction is discarded. These take priority over a simultaneous accept, which is dropped. The fetch stage zeroes its own address on the same clear.
- `uop_avail` is registered from the next-state comparison (`wr_ptr_next != rd_addr`).

## Timing

- Reset values: `stalled`=0 (since `rd_addr`=0 and `wr_ptr`=0, the buffer is not full), `uop_avail`=0, FSM=EMPTY, `wr_ptr`=0. `uop` is X until its entry is written; the bench must not check it before then.
- Write latency: an entry written at edge N is visible on `uop` (when `rd_addr` points at it) and raises `uop_avail` after edge N, in cycle N+1.
- Pairing latency: a pair occupies two accept cycles; the entry is written at the second accept edge.
- Read: `uop` is purely combinational from `rd_addr` and the memory. A write and a read to different entries in the same cycle do not interact. A read of the entry being written returns the old data until the edge.
- Full release: when `rd_addr` advances, `stalled` drops combinationally in the same cycle.
- Wrap-around: `wr_ptr` goes from SIZE−1 to 0 with no special handling.

## Test plan

- Reset, then feed 4 instructions A0..A3 (tags 1..4, `in_last`=0) back-to-back → entry0 = {tag 1, tag 2, A1, A0}, entry1 = {tag 3, tag 4, A3, A2}. `uop_avail` rises the cycle after the 2nd accept. `wr_ptr`=2.
- A single instruction B with `in_last`=1 from EMPTY → entry = {tag B, tag 0, 32'h13, B}, written on the same edge. An odd count ending in HALF with `in_last`=1 on the pair-completing instruction → no padding.
- Hold `rd_addr`=0 and stream 2*(SIZE−1) instructions → `stalled` asserts after the 15th entry (SIZE=16). Further inputs are held, not lost. Stepping `rd_addr` to 1 → `stalled`=0 in the same cycle and the next pair is written at entry 15.
- Drain and refill across the wrap → entries land at 15 then 0. `uop_avail` tracks `wr_ptr != rd_addr` correctly through the wrap.
- Accept one instruction (HALF), then assert `clear` together with `in_valid` → FSM=EMPTY, `wr_ptr`=0, `uop_avail`=0. Neither the held nor the concurrent instruction appears in any later entry.
- Assert `reset` mid-stream with the buffer half full → all outputs return to their reset values on the next cycle.

Source files
------------

// File: rtl/uop_fill.sv
// Write side of the micro-op buffer: pairs decoded instructions into two-slot
// entries and writes them into a circular buffer read asynchronously by fetch.
//
// state | meaning
// EMPTY | no instruction held; next accept starts a pair (or writes a padded single)
// HALF  | slot-1 instruction held in h_instr/h_tag, waiting for slot 2
module uop_fill #(
  parameter int          UOP_BUF_SIZE           = 16,
  parameter int          MAX_PREDICT_DEPTH_BITS = 4,
  parameter int          UOP_BUF_WIDTH          = 72,
  parameter logic [31:0] NOP_INSTR              = 32'h0000_0013
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               clear,
  input  logic                               in_valid,
  input  logic [31:0]                        in_instr,
  input  logic [MAX_PREDICT_DEPTH_BITS-1:0]  in_tag,
  input  logic                               in_last,
  output logic                               stalled,
  input  logic [$clog2(UOP_BUF_SIZE)-1:0]    rd_addr,
  output logic [UOP_BUF_WIDTH-1:0]           uop,
  output logic                               uop_avail
);

  localparam int AW = $clog2(UOP_BUF_SIZE);
  localparam int B  = MAX_PREDICT_DEPTH_BITS;

  typedef enum logic {EMPTY, HALF} state_t;

  state_t                   state;
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            wr_ptr_inc;
  logic [AW-1:0]            wr_ptr_next;
  logic [31:0]              h_instr;
  logic [B-1:0]             h_tag;
  logic [UOP_BUF_WIDTH-1:0] mem [UOP_BUF_SIZE];
  logic [UOP_BUF_WIDTH-1:0] wr_data;
  logic                     full;
  logic                     accept;
  logic                     wr_en;

  // One slot stays unused so that wr_ptr == rd_addr unambiguously means empty.
  assign wr_ptr_inc  = wr_ptr + AW'(1);
  assign full        = (wr_ptr_inc == rd_addr);
  assign stalled     = full;
  assign accept      = in_valid && !full;
  assign wr_en       = accept && (state == HALF || in_last) && !reset && !clear;
  assign wr_ptr_next = wr_en ? wr_ptr_inc : wr_ptr;

  always_comb begin
    wr_data = '0;
    if (state == HALF)
      wr_data = {h_tag, in_tag, in_instr, h_instr};
    else
      wr_data = {in_tag, {B{1'b0}}, NOP_INSTR, in_instr};
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state     <= EMPTY;
      wr_ptr    <= '0;
      uop_avail <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_next;
      uop_avail <= (wr_ptr_next != rd_addr);
      if (accept) begin
        case (state)
          EMPTY: begin
            if (!in_last) begin
              h_instr <= in_instr;
              h_tag   <= in_tag;
              state   <= HALF;
            end
          end
          HALF:    state <= EMPTY;
          default: state <= EMPTY;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= wr_data;
  end

  assign uop = mem[rd_addr];

endmodule

// File: tb/tb_uop_fill.sv
// Bench for uop_fill: directed scenarios plus random traffic, checked against a
// slot-queue model of the pairing buffer.
module tb_uop_fill;

  localparam int SIZE = 16;
  localparam int B    = 4;
  localparam int W    = 72;
  localparam int AW   = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          reset, clear, in_valid, in_last;
  logic [31:0]   in_instr;
  logic [B-1:0]  in_tag;
  logic          stalled;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  uop;
  logic          uop_avail;

  uop_fill #(
    .UOP_BUF_SIZE(SIZE), .MAX_PREDICT_DEPTH_BITS(B), .UOP_BUF_WIDTH(W), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_instr(in_instr),
    .in_tag(in_tag), .in_last(in_last), .stalled(stalled), .rd_addr(rd_addr),
    .uop(uop), .uop_avail(uop_avail)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] instr; logic [B-1:0] tag; } slot_t;

  // reference model: write count, pending slots, expected memory image
  int         m_wp;
  bit         m_avail;
  bit         m_started;
  slot_t      pend[$];
  logic [W-1:0] exp_mem [SIZE];
  bit         known [SIZE];
  int         rd;
  int         n_assert = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic bit model_full();
    return ((m_wp + 1) % SIZE) == rd;
  endfunction

  // one clock: drive, check pre-edge outputs, clock, update model; returns accept
  task automatic cycle(input bit v, input logic [31:0] ins, input logic [B-1:0] tg,
                       input bit lst, input bit clr, input bit rst, output bit acc);
    slot_t s1, s2;
    in_valid = v; in_instr = ins; in_tag = tg; in_last = lst;
    clear = clr; reset = rst; rd_addr = AW'(rd);
    #1;
    if (m_started) begin
      check("stalled", W'(stalled), W'(model_full()));
      check("uop_avail", W'(uop_avail), W'(m_avail));
      if (known[rd]) check("uop", uop, exp_mem[rd]);
    end
    acc = v && !model_full() && !clr && !rst;
    @(posedge clk);
    #1;
    if (rst || clr) begin
      m_wp = 0; pend.delete(); m_avail = 0; m_started = 1;
    end else begin
      if (acc) begin
        pend.push_back('{ins, tg});
        if (pend.size() == 2 || lst) begin
          s1 = pend[0];
          if (pend.size() == 2) s2 = pend[1];
          else s2 = '{NOP, '0};
          exp_mem[m_wp] = {s1.tag, s2.tag, s2.instr, s1.instr};
          known[m_wp] = 1;
          m_wp = (m_wp + 1) % SIZE;
          pend.delete();
        end
      end
      m_avail = (m_wp != rd);
    end
  endtask

  task automatic peek(input int addr, input logic [W-1:0] exp, input string name);
    rd_addr = AW'(addr);
    #1;
    check(name, uop, exp);
    rd_addr = AW'(rd);
    #1;
  endtask

  // random traffic; an instruction is held until accepted
  task automatic feed(input int n, input int p_valid, input int p_last, input bit move_rd);
    bit acc;
    bit have = 0;
    logic [31:0] ins;
    logic [B-1:0] tg;
    bit lst;
    for (int i = 0; i < n; i++) begin
      if (!have) begin
        ins = $urandom; tg = B'($urandom); lst = ($urandom_range(0, 99) < p_last);
        have = 1;
      end
      if (move_rd && rd != m_wp && $urandom_range(0, 99) < 40) rd = (rd + 1) % SIZE;
      cycle(($urandom_range(0, 99) < p_valid), ins, tg, lst, 0, 0, acc);
      if (acc) have = 0;
    end
  endtask

  initial begin
    bit acc;
    logic [31:0] a [4];
    logic [31:0] bi, c0, c1, x0, x1;
    int guard;
    m_wp = 0; m_avail = 0; m_started = 0; rd = 0;
    for (int i = 0; i < SIZE; i++) known[i] = 0;

    // reset
    cycle(0, 0, 0, 0, 0, 1, acc);
    cycle(0, 0, 0, 0, 0, 1, acc);
    cycle(0, 0, 0, 0, 0, 0, acc);
    check("reset_stalled", W'(stalled), W'(0));
    check("reset_avail", W'(uop_avail), W'(0));

    // four back-to-back instructions form two entries
    for (int i = 0; i < 4; i++) a[i] = $urandom;
    for (int i = 0; i < 4; i++) cycle(1, a[i], B'(i + 1), 0, 0, 0, acc);
    cycle(0, 0, 0, 0, 0, 0, acc);
    check("pair_avail", W'(uop_avail), W'(1));
    peek(0, {4'd1, 4'd2, a[1], a[0]}, "entry0");
    peek(1, {4'd3, 4'd4, a[3], a[2]}, "entry1");

    // lone instruction padded; odd pair closed by in_last without padding
    bi = $urandom; c0 = $urandom; c1 = $urandom;
    cycle(1, bi, 4'd9, 1, 0, 0, acc);
    peek(2, {4'd9, 4'd0, NOP, bi}, "entry_padded");
    cycle(1, c0, 4'd5, 0, 0, 0, acc);
    cycle(1, c1, 4'd6, 1, 0, 0, acc);
    peek(3, {4'd5, 4'd6, c1, c0}, "entry_odd_close");

    // fill to capacity with rd_addr held at 0
    guard = 0;
    while (m_wp != SIZE - 1 && guard < 200) begin
      cycle(1, $urandom, B'($urandom), 0, 0, 0, acc);
      guard++;
    end
    check("fill_bound", W'(m_wp), W'(SIZE - 1));
    cycle(1, 32'hDEAD_0001, 4'd7, 0, 0, 0, acc);
    check("full_stalled", W'(stalled), W'(1));
    cycle(1, 32'hDEAD_0001, 4'd7, 0, 0, 0, acc);
    rd = 1;
    cycle(1, 32'hDEAD_0001, 4'd7, 0, 0, 0, acc);
    cycle(1, 32'hDEAD_0002, 4'd8, 0, 0, 0, acc);
    peek(15, {4'd7, 4'd8, 32'hDEAD_0002, 32'hDEAD_0001}, "entry15_after_release");
    check("wrap_full", W'(stalled), W'(1));

    // drain and refill across the wrap
    feed(400, 70, 25, 1);

    // clear while a half instruction is held
    rd = 0;
    cycle(0, 0, 0, 0, 1, 0, acc);
    cycle(1, 32'hBAD0_0001, 4'd3, 0, 0, 0, acc);
    cycle(1, 32'hBAD0_0002, 4'd4, 0, 1, 0, acc);
    check("clear_avail", W'(uop_avail), W'(0));
    x0 = $urandom; x1 = $urandom;
    cycle(1, x0, 4'd1, 0, 0, 0, acc);
    cycle(1, x1, 4'd2, 0, 0, 0, acc);
    peek(0, {4'd1, 4'd2, x1, x0}, "entry0_after_clear");

    // reset mid-stream with the buffer half full
    feed(20, 100, 0, 0);
    cycle(1, $urandom, 4'd1, 0, 0, 1, acc);
    cycle(0, 0, 0, 0, 0, 0, acc);
    check("midreset_avail", W'(uop_avail), W'(0));
    check("midreset_stalled", W'(stalled), W'(0));

    feed(100, 60, 30, 1);
    cycle(0, 0, 0, 0, 0, 0, acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
